// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS main controller.
// The master side (controller) drives the enables and selects; the slave side (datapath) returns status.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;
    logic [1:0] opAlu;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcEn;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic [3:0] state;

    modport master (
        input  opcode, zero, memReady,
        output opAlu, aluSrcA, aluSrcB, pcSrc, pcWrite, pcWriteCond, pcEn,
               iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, state
    );

    modport slave (
        output opcode, zero, memReady,
        input  opAlu, aluSrcA, aluSrcB, pcSrc, pcWrite, pcWriteCond, pcEn,
               iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select, stalling on the memory-ready handshake.
module mips_multicycle_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic                        clk,
    input logic                        rst,
    mips_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Moore part of the outputs; the fetch flag is later qualified by memReady for irWrite/pcWrite.
    typedef struct packed {
        logic [1:0] opAlu;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       fetch;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memRead = 1'b1;
                c.aluSrcB = 2'b01;
                c.fetch   = 1'b1;
            end
            DECODE: c.aluSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            MEMRD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            MEMWB: begin
                c.memToReg = 1'b1;
                c.regWrite = 1'b1;
            end
            MEMWR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            EXEC: begin
                c.aluSrcA = 1'b1;
                c.opAlu   = 2'b10;
            end
            ALUWB: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.opAlu       = 2'b01;
                c.pcSrc       = 2'b01;
                c.pcWriteCond = 1'b1;
            end
            ADDIWB: c.regWrite = 1'b1;
            JUMP: begin
                c.pcSrc   = 2'b10;
                c.pcWrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_state(state_t s, logic [5:0] op, logic ready);
        case (s)
            FETCH:  return ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: return MEMADR;
                    OP_RTYPE:     return EXEC;
                    OP_BEQ:       return BRANCH;
                    OP_ADDI:      return ADDIEX;
                    OP_J:         return JUMP;
                    default:      return FETCH;
                endcase
            end
            MEMADR: return (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  return ready ? MEMWB : MEMRD;
            MEMWR:  return ready ? FETCH : MEMWR;
            EXEC:   return ALUWB;
            ADDIEX: return ADDIWB;
            default: return FETCH;
        endcase
    endfunction

    state_t cur;
    state_t nxt;
    ctrl_t  ctl;
    logic   ready;
    logic   run;

    assign ready = MEM_WAIT_EN ? bus.memReady : 1'b1;
    assign run   = ~rst;

    always_comb begin
        nxt = next_state(cur, bus.opcode, ready);
    end

    // Outputs are registered alongside the state so they always match the state just entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= FETCH;
            ctl <= decode_ctrl(FETCH);
        end else begin
            cur <= nxt;
            ctl <= decode_ctrl(nxt);
        end
    end

    assign bus.state       = cur;
    assign bus.opAlu       = run ? ctl.opAlu   : 2'b00;
    assign bus.aluSrcA     = run & ctl.aluSrcA;
    assign bus.aluSrcB     = run ? ctl.aluSrcB : 2'b00;
    assign bus.pcSrc       = run ? ctl.pcSrc   : 2'b00;
    assign bus.iorD        = run & ctl.iorD;
    assign bus.memRead     = run & ctl.memRead;
    assign bus.memWrite    = run & ctl.memWrite;
    assign bus.regDst      = run & ctl.regDst;
    assign bus.memToReg    = run & ctl.memToReg;
    assign bus.regWrite    = run & ctl.regWrite;
    assign bus.irWrite     = run & ctl.fetch & ready;
    assign bus.pcWrite     = run & (ctl.pcWrite | (ctl.fetch & ready));
    assign bus.pcWriteCond = run & ctl.pcWriteCond;
    assign bus.pcEn        = bus.pcWrite | (bus.pcWriteCond & bus.zero);
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: spec-table vectors, reset corner cases and random instruction streams.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   trace[$];

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [1:0] opAlu;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcEn;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {bus.opAlu, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.pcWrite, bus.pcWriteCond,
                    bus.pcEn, bus.iorD, bus.memRead, bus.memWrite, bus.irWrite, bus.regDst,
                    bus.memToReg, bus.regWrite};

    // Output table straight from the state descriptions; unlisted outputs stay 0.
    function automatic outs_t exp_outs(int st, logic mr, logic z, logic r);
        outs_t o;
        o = '0;
        if (r) return o;
        case (st)
            0:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = mr; o.pcWrite = mr; end
            1:  o.aluSrcB = 2'b11;
            2:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            3:  begin o.memRead = 1; o.iorD = 1; end
            4:  begin o.memToReg = 1; o.regWrite = 1; end
            5:  begin o.memWrite = 1; o.iorD = 1; end
            6:  begin o.aluSrcA = 1; o.opAlu = 2'b10; end
            7:  begin o.regDst = 1; o.regWrite = 1; end
            8:  begin o.aluSrcA = 1; o.opAlu = 2'b01; o.pcSrc = 2'b01; o.pcWriteCond = 1; end
            9:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            10: o.regWrite = 1;
            11: begin o.pcSrc = 2'b10; o.pcWrite = 1; end
            default: o = '0;
        endcase
        o.pcEn = o.pcWrite | (o.pcWriteCond & z);
        return o;
    endfunction

    function automatic int base_cycles(logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic bit is_mem(logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Expected visit list of states for one instruction, including stall repetitions.
    task automatic build_trace(logic [5:0] op, int fst, int dst);
        trace.delete();
        repeat (fst + 1) trace.push_back(0);
        trace.push_back(1);
        case (op)
            6'b100011: begin trace.push_back(2); repeat (dst + 1) trace.push_back(3); trace.push_back(4); end
            6'b101011: begin trace.push_back(2); repeat (dst + 1) trace.push_back(5); end
            6'b000000: begin trace.push_back(6); trace.push_back(7); end
            6'b000100: trace.push_back(8);
            6'b001000: begin trace.push_back(9); trace.push_back(10); end
            6'b000010: trace.push_back(11);
            default: ;
        endcase
    endtask

    task automatic run_instr(string name, logic [5:0] op, int fst, int dst, logic z,
                             int exp_cycles, bit scramble);
        int n;
        int st;
        logic mr;
        build_trace(op, fst, dst);
        n = 0;
        do begin
            @(negedge clk);
            st = (n < trace.size()) ? trace[n] : 0;
            mr = !((n + 1 < trace.size()) && (trace[n + 1] == trace[n]));
            bus.memReady = mr;
            bus.zero     = z;
            bus.opcode   = (!scramble || st == 1 || st == 2) ? op : 6'($urandom);
            #1;
            chk({name, " state"}, 32'(bus.state), 32'(st));
            chk({name, " outputs"}, 32'(dut_o), 32'(exp_outs(st, mr, z, 1'b0)));
            @(posedge clk);
            #1;
            n++;
        end while ((n <= fst || bus.state != 4'd0) && n < 20);
        chk({name, " cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic step(logic [5:0] op, logic mr);
        @(negedge clk);
        bus.opcode   = op;
        bus.memReady = mr;
        bus.zero     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles entered from the current state, then release into a non-advancing FETCH.
    task automatic reset_seq(string name);
        @(negedge clk);
        rst = 1'b1;
        bus.memReady = 1'b0;
        #1;
        chk({name, " outs in rst"}, 32'(dut_o), 32'(exp_outs(0, 1'b0, 1'b0, 1'b1)));
        chk({name, " memWrite in rst"}, 32'(bus.memWrite), 32'd0);
        @(negedge clk);
        #1;
        chk({name, " state in rst"}, 32'(bus.state), 32'd0);
        chk({name, " regWrite in rst"}, 32'(bus.regWrite), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({name, " state after rst"}, 32'(bus.state), 32'd0);
        chk({name, " outs after rst"}, 32'(dut_o), 32'(exp_outs(0, 1'b0, 1'b0, 1'b0)));
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        int         fst;
        int         dst;
        logic       z;
        int         cycles;
    } vec_t;

    vec_t vecs[11];
    logic [5:0] legal_ops[6];

    initial begin
        vecs[0]  = '{"rtype",        6'b000000, 0, 0, 1'b0, 4};
        vecs[1]  = '{"lw",           6'b100011, 0, 0, 1'b0, 5};
        vecs[2]  = '{"lw stall2",    6'b100011, 0, 2, 1'b0, 7};
        vecs[3]  = '{"sw",           6'b101011, 0, 0, 1'b0, 4};
        vecs[4]  = '{"sw stall1",    6'b101011, 0, 1, 1'b1, 5};
        vecs[5]  = '{"addi",         6'b001000, 0, 0, 1'b0, 4};
        vecs[6]  = '{"beq taken",    6'b000100, 0, 0, 1'b1, 3};
        vecs[7]  = '{"beq not",      6'b000100, 0, 0, 1'b0, 3};
        vecs[8]  = '{"j",            6'b000010, 0, 0, 1'b0, 3};
        vecs[9]  = '{"illegal 3f",   6'b111111, 0, 0, 1'b1, 2};
        vecs[10] = '{"fetch stall3", 6'b000000, 3, 0, 1'b0, 7};
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

        rst = 1'b1;
        bus.opcode = 6'b0;
        bus.zero = 1'b0;
        bus.memReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(bus.state), 32'd0);
        chk("reset outs", 32'(dut_o), 32'(exp_outs(0, 1'b0, 1'b0, 1'b1)));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            run_instr(vecs[i].name, vecs[i].op, vecs[i].fst, vecs[i].dst, vecs[i].z,
                      vecs[i].cycles, 1'b0);

        // Reset while a store is stalled in MEMWR.
        step(6'b101011, 1'b1);
        step(6'b101011, 1'b1);
        step(6'b101011, 1'b1);
        @(negedge clk);
        bus.memReady = 1'b0;
        #1;
        chk("memwr stall state", 32'(bus.state), 32'd5);
        chk("memwr stall memWrite", 32'(bus.memWrite), 32'd1);
        @(posedge clk);
        #1;
        chk("memwr held", 32'(bus.state), 32'd5);
        reset_seq("rst memwr");
        run_instr("post rst rtype", 6'b000000, 0, 0, 1'b0, 4, 1'b0);

        // Reset from the R-type writeback cycle.
        step(6'b000000, 1'b1);
        step(6'b000000, 1'b1);
        step(6'b000000, 1'b1);
        chk("aluwb reached", 32'(bus.state), 32'd7);
        reset_seq("rst aluwb");
        run_instr("post rst lw", 6'b100011, 1, 1, 1'b0, 7, 1'b0);

        for (int k = 0; k < 150; k++) begin
            logic [5:0] op;
            int sel, fst, dst;
            logic z;
            sel = $urandom_range(0, 6);
            if (sel < 6) op = legal_ops[sel];
            else begin
                op = 6'($urandom);
                while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                    op = 6'($urandom);
            end
            fst = $urandom_range(0, 2);
            dst = $urandom_range(0, 3);
            z = 1'($urandom);
            run_instr($sformatf("rand%0d op%b", k, op), op, fst, dst, z,
                      base_cycles(op) + fst + (is_mem(op) ? dst : 0), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
